// File: rtl/usb3_slfifo_writer_if.sv
// Bundle of capture-side handshake and FX3 slave-FIFO write-bus signals.
// Capture handshake: a word transfers on a rising clock edge where in_valid && in_ready are both high;
// in_data must be stable while in_valid is high, and in_ready never depends on in_valid.
interface usb3_slfifo_writer_if #(
  parameter int DATA_W = 32,
  parameter int LVL_W  = 10
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              USB3_FLAGA;
  logic              USB3_SLWR_N;
  logic              USB3_PKTEND_N;
  logic [DATA_W-1:0] USB3_DQ_OUT;
  logic              USB3_DQ_OE;
  logic [1:0]        USB3_A;
  logic [3:0]        usb_wr_state;
  logic              flag_err;
  logic [LVL_W-1:0]  level;

  modport master (
    input  in_data, in_valid, flush, USB3_FLAGA,
    output in_ready, USB3_SLWR_N, USB3_PKTEND_N, USB3_DQ_OUT, USB3_DQ_OE, USB3_A,
           usb_wr_state, flag_err, level
  );

  modport slave (
    output in_data, in_valid, flush, USB3_FLAGA,
    input  in_ready, USB3_SLWR_N, USB3_PKTEND_N, USB3_DQ_OUT, USB3_DQ_OE, USB3_A,
           usb_wr_state, flag_err, level
  );
endinterface

// File: rtl/usb3_slfifo_writer.sv
// FX3 slave-FIFO upload writer: buffers capture words and writes fixed bursts or flushed short packets.
// Optional zero-length packet on an empty flush is enabled by defining USB3_ZLP_EN.
module usb3_slfifo_writer #(
  parameter int         DATA_W     = 32,
  parameter int         BURST_LEN  = 256,
  parameter int         FIFO_DEPTH = 512,
  parameter int         COOL_CYC   = 4,
  parameter logic [1:0] USB_ADDR   = 2'b00
) (
  input logic                   clock,
  input logic                   rst,
  usb3_slfifo_writer_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_BURST  = 4'd1;
  localparam logic [3:0] S_SHORT  = 4'd2;
  localparam logic [3:0] S_PKTEND = 4'd3;
  localparam logic [3:0] S_COOL   = 4'd4;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     cnt, next_cnt;
  logic [3:0]        state, next_state;
  logic              flush_pending, clr_flush;
  logic              flag_err;
  logic              push, pop;
  logic              slwr_n, pktend_n, dq_oe;
  logic              slwr_d, pktend_d, oe_d;
  logic [DATA_W-1:0] dq_out;

  assign bus.in_ready = (level != LW'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // cnt holds words left in the current packet, or cycles left in COOL.
  always_comb begin
    next_state = S_IDLE;
    next_cnt   = cnt;
    clr_flush  = 1'b0;
    case (state)
      S_IDLE: begin
        next_state = S_IDLE;
        if (bus.USB3_FLAGA && level >= LW'(BURST_LEN)) begin
          next_state = S_BURST;
          next_cnt   = LW'(BURST_LEN);
        end else if (flush_pending && bus.USB3_FLAGA && level != '0) begin
          next_state = S_SHORT;
          next_cnt   = level;
        end else if (flush_pending && level == '0) begin
`ifdef USB3_ZLP_EN
          if (bus.USB3_FLAGA) next_state = S_PKTEND;
`else
          clr_flush = 1'b1;
`endif
        end
      end
      S_BURST: begin
        next_state = (cnt == LW'(1)) ? S_COOL : S_BURST;
        next_cnt   = (cnt == LW'(1)) ? LW'(COOL_CYC) : cnt - LW'(1);
      end
      S_SHORT: begin
        next_state = (cnt == LW'(1)) ? S_PKTEND : S_SHORT;
        next_cnt   = cnt - LW'(1);
      end
      S_PKTEND: begin
        clr_flush  = 1'b1;
        next_state = S_COOL;
        next_cnt   = LW'(COOL_CYC);
      end
      S_COOL: begin
        next_state = (cnt == LW'(1)) ? S_IDLE : S_COOL;
        next_cnt   = cnt - LW'(1);
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Pad outputs are registered from the upcoming state, so a word pops on the
  // same edge its strobe goes low and the strobe run has no gaps.
  always_comb begin
    slwr_d   = 1'b1;
    pktend_d = 1'b1;
    oe_d     = 1'b0;
    pop      = 1'b0;
    case (next_state)
      S_BURST, S_SHORT: begin
        slwr_d = 1'b0;
        oe_d   = 1'b1;
        pop    = 1'b1;
      end
      S_PKTEND: begin
        pktend_d = 1'b0;
        oe_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      flush_pending <= 1'b0;
      flag_err      <= 1'b0;
      slwr_n        <= 1'b1;
      pktend_n      <= 1'b1;
      dq_oe         <= 1'b0;
      dq_out        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      // A new flush wins over a same-cycle clear so no request is lost.
      if (bus.flush)     flush_pending <= 1'b1;
      else if (clr_flush) flush_pending <= 1'b0;
      if ((state == S_BURST || state == S_SHORT) && !bus.USB3_FLAGA) flag_err <= 1'b1;
      slwr_n   <= slwr_d;
      pktend_n <= pktend_d;
      dq_oe    <= oe_d;
      dq_out   <= pop ? mem[rd_ptr] : '0;
    end
  end

  assign bus.USB3_SLWR_N   = slwr_n;
  assign bus.USB3_PKTEND_N = pktend_n;
  assign bus.USB3_DQ_OE    = dq_oe;
  assign bus.USB3_DQ_OUT   = dq_out;
  assign bus.USB3_A        = USB_ADDR;
  assign bus.usb_wr_state  = state;
  assign bus.flag_err      = flag_err;
  assign bus.level         = level;
endmodule

// File: doc/usb3_slfifo_writer.md
Name: usb3_slfifo_writer

Overview:
- Upload-path master for the FX3 slave FIFO: buffers 32-bit sample words from the ADC/capture side and writes them to the USB3 GPIF bus in fixed bursts sized to one FX3 DMA buffer.
- Issues a short packet on flush; optionally issues a zero-length packet.
- Sits between the capture datapath and the USB3 pad interface. It is the transmit counterpart of the download-side cache/read logic.

Parameters:
- DATA_W, 32, width of the data word and the USB3 DQ bus.
- BURST_LEN, 256, words per full burst (one FX3 DMA buffer).
- FIFO_DEPTH, 512, internal buffer depth in words; power of two, >= BURST_LEN.
- COOL_CYC, 4, idle cycles after every burst or packet end, covering FX3 flag latency.
- USB_ADDR, 2'b00, FX3 socket address driven on USB3_A.

Ports:
- clock  in  1  single system/GPIF clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  DATA_W  capture word.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  FIFO can accept a word; low when full.
- flush  in  1  one-cycle pulse: send the buffered remainder as a short packet.
- USB3_FLAGA  in  1  FX3 thread-ready flag; high means a buffer is available.
- USB3_SLWR_N  out  1  FX3 write strobe, active-low.
- USB3_PKTEND_N  out  1  FX3 packet end, active-low.
- USB3_DQ_OUT  out  DATA_W  data to the DQ pads.
- USB3_DQ_OE  out  1  DQ output enable.
- USB3_A  out  2  socket address, constant USB_ADDR.
- usb_wr_state  out  4  current FSM state code.
- flag_err  out  1  sticky: FLAGA fell during a burst.
- level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values:
  - SLWR_N=1, PKTEND_N=1, DQ_OE=0, DQ_OUT=0.
  - in_ready=1, level=0, flag_err=0, usb_wr_state=0.
  - FIFO pointers and flush_pending cleared.
- Reset is asynchronous and effective immediately, including mid-burst; no partial state survives it.
- FIFO push/pop rules:
  - Push when in_valid && in_ready. in_ready = (level != FIFO_DEPTH).
  - Push and pop in the same cycle are allowed; level is unchanged.
  - A push while full is dropped. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE=0, BURST=1, SHORT=2, PKTEND=3, COOL=4. Codes 5-15 are illegal and recover to IDLE on the next edge.
- IDLE:
  - If FLAGA=1 and level >= BURST_LEN, go to BURST with cnt=BURST_LEN.
  - Else if flush_pending and FLAGA=1 and 0 < level < BURST_LEN, go to SHORT with cnt=level, sampled at entry.
  - Else if flush_pending and level=0, clear flush_pending and stay (ZLP handling is under Optional Feature).
  - The full-burst condition has priority over flush.
- BURST and SHORT:
  - Each cycle: SLWR_N=0, DQ_OE=1, one FIFO word popped and driven on DQ_OUT in the same registered cycle, cnt decremented.
  - When cnt reaches 1: BURST goes to COOL; SHORT goes to PKTEND.
  - Latency: condition true at edge k gives SLWR_N low for edges k+1 .. k+cnt, with no gaps.
- PKTEND: SLWR_N=1, PKTEND_N=0 for exactly one cycle, DQ_OE=1. Clears flush_pending, then goes to COOL.
- COOL: all strobes high, DQ_OE=0 for COOL_CYC cycles, then IDLE. FLAGA is sampled only in IDLE.
- Flush latching: a flush pulse in any state sets flush_pending. It is serviced at the next eligible IDLE. Multiple pulses merge into one.
- FLAGA falling while in BURST or SHORT:
  - The burst completes anyway, because burst length equals the FX3 buffer size.
  - flag_err sets and stays set until rst.
- usb_wr_state equals the registered state code.
- level is a registered output and updates on the edge after a push or pop.

Optional Feature:
- Macro USB3_ZLP_EN.
- Defined: in IDLE with flush_pending, level=0 and FLAGA=1, go to PKTEND directly. This gives a zero-length packet: PKTEND_N low for 1 cycle with SLWR_N high the whole time, then COOL.
- Undefined: a flush with an empty FIFO is discarded; flush_pending clears and no bus activity occurs.

Test Plan:
- Push 256 words (0x00000000..0x000000FF), FLAGA=1 -> exactly 256 contiguous SLWR_N-low cycles, DQ_OUT in order, PKTEND_N never low, then 4 COOL cycles, level=0.
- Push 100 words, then pulse flush, FLAGA=1 -> 100 SLWR_N-low cycles, then one PKTEND_N-low cycle, then COOL; flush_pending cleared.
- FLAGA=0 while 300 words buffered, then raise FLAGA -> burst starts on the edge after the rise; 44 words remain, level=44.
- Fill to 512 with continuous in_valid -> in_ready=0 at level=512, the 513th word is dropped; a simultaneous push and pop during the burst keeps level constant.
- Drop FLAGA at word 50 of a burst -> all 256 words still written, flag_err=1; assert rst at word 120 of the next burst -> SLWR_N=1 immediately, level=0, flag_err=0.
- Flush with an empty FIFO -> with USB3_ZLP_EN: one PKTEND_N pulse, SLWR_N stays high; without it: no strobe activity.
